// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, control enums and bundle type for the ID stage
package decode_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_JAL  = 2'b01,
    JUMP_JALR = 2'b10
  } jump_e;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    jump_e   jump;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate extraction and sign extension to XLEN
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate for the format; bit 31 always carries instr[31]
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widening a signed value replicates bit 31 up to XLEN
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_decoder.sv
// rtl/id_stage_decoder.sv - registered, handshaked RV32I/RV64I decode stage
module id_stage_decoder
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic            alu_src_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            branch_o,
  output logic [1:0]      jump_o,
  output logic [1:0]      alu_op_o,
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  ctrl_t           dec_ctrl;
  ctrl_t           ctrl_q;
  imm_fmt_e        dec_fmt;
  logic            use_rs1, use_rs2, use_rd, bad;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            hazard;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Classify the incoming word; an illegal encoding collapses to an empty bundle with the flag set
  always_comb begin
    dec_ctrl = '0;
    dec_fmt  = FMT_NONE;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    bad      = 1'b0;
    case (opcode)
      OPC_R: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_RTYPE;
        {use_rs1, use_rs2, use_rd} = 3'b111;
        bad = !(funct7 inside {7'b0000000, 7'b0100000}) ||
              (funct7 == 7'b0100000 && !(funct3 inside {3'b000, 3'b101}));
      end
      OPC_I: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_ITYPE;
        dec_fmt            = FMT_I;
        {use_rs1, use_rd}  = 2'b11;
      end
      OPC_LOAD: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_fmt             = FMT_I;
        {use_rs1, use_rd}   = 2'b11;
        bad = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_fmt            = FMT_S;
        {use_rs1, use_rs2} = 2'b11;
        bad = !(funct3 inside {3'b000, 3'b001, 3'b010});
      end
      OPC_BRANCH: begin
        dec_ctrl.branch    = 1'b1;
        dec_ctrl.alu_op    = ALU_BRANCH;
        dec_fmt            = FMT_B;
        {use_rs1, use_rs2} = 2'b11;
        bad = funct3 inside {3'b010, 3'b011};
      end
      OPC_JAL: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump      = JUMP_JAL;
        dec_fmt            = FMT_J;
        use_rd             = 1'b1;
      end
      OPC_JALR: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump      = JUMP_JALR;
        dec_fmt            = FMT_I;
        {use_rs1, use_rd}  = 2'b11;
        bad = funct3 != 3'b000;
      end
      OPC_LUI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_fmt            = FMT_U;
        use_rd             = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec_ctrl         = '0;
      dec_ctrl.illegal = 1'b1;
      dec_fmt          = FMT_NONE;
      use_rs1          = 1'b0;
      use_rs2          = 1'b0;
      use_rd           = 1'b0;
    end
  end

  assign dec_rs1 = use_rs1 ? instr_i[19:15] : 5'd0;
  assign dec_rs2 = use_rs2 ? instr_i[24:20] : 5'd0;
  assign dec_rd  = use_rd  ? instr_i[11:7]  : 5'd0;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_i),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  // Unused source fields are already zero, so they can never match a nonzero load destination
  assign hazard = valid_o && ctrl_q.mem_read && (rd_o != 5'd0) && valid_i &&
                  ((dec_rs1 == rd_o) || (dec_rs2 == rd_o));

  assign ready_o = !rst_i ? 1'b0 :
                   flush_i ? 1'b1 :
                   (!valid_o || ready_i) && !hazard;

  // Output register: reset beats flush, flush beats accept; a stalled bundle stays put
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      imm_o      <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
      ctrl_q     <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (valid_i && ready_o) begin
      valid_o    <= 1'b1;
      pc_o       <= pc_i;
      imm_o      <= dec_imm;
      rs1_o      <= dec_rs1;
      rs2_o      <= dec_rs2;
      rd_o       <= dec_rd;
      funct3_o   <= funct3;
      funct7b5_o <= instr_i[30];
      ctrl_q     <= dec_ctrl;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  assign alu_src_o    = ctrl_q.alu_src;
  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign branch_o     = ctrl_q.branch;
  assign jump_o       = ctrl_q.jump;
  assign alu_op_o     = ctrl_q.alu_op;
  assign illegal_o    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_decoder.sv
// tb/tb_id_stage_decoder.sv - directed self-checking bench for id_stage_decoder
module tb_id_stage_decoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b1;
  wire  [63:0] pc64_i = {32'h0, pc_i};

  logic        ready_o, valid_o, funct7b5_o, alu_src_o, reg_write_o, mem_read_o;
  logic        mem_write_o, mem_to_reg_o, branch_o, illegal_o;
  logic [31:0] pc_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic [1:0]  jump_o, alu_op_o;

  logic        w_ready_o, w_valid_o, w_funct7b5_o, w_alu_src_o, w_reg_write_o, w_mem_read_o;
  logic        w_mem_write_o, w_mem_to_reg_o, w_branch_o, w_illegal_o;
  logic [63:0] w_pc_o, w_imm_o;
  logic [4:0]  w_rs1_o, w_rs2_o, w_rd_o;
  logic [2:0]  w_funct3_o;
  logic [1:0]  w_jump_o, w_alu_op_o;

  wire [9:0] ctrl_v = {alu_src_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o,
                       branch_o, jump_o, alu_op_o};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_stage_decoder #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i),
    .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .alu_src_o(alu_src_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o), .jump_o(jump_o),
    .alu_op_o(alu_op_o), .illegal_o(illegal_o)
  );

  id_stage_decoder #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc64_i), .valid_i(valid_i),
    .ready_o(w_ready_o), .flush_i(flush_i), .valid_o(w_valid_o), .ready_i(ready_i),
    .pc_o(w_pc_o), .imm_o(w_imm_o), .rs1_o(w_rs1_o), .rs2_o(w_rs2_o), .rd_o(w_rd_o),
    .funct3_o(w_funct3_o), .funct7b5_o(w_funct7b5_o), .alu_src_o(w_alu_src_o),
    .reg_write_o(w_reg_write_o), .mem_read_o(w_mem_read_o), .mem_write_o(w_mem_write_o),
    .mem_to_reg_o(w_mem_to_reg_o), .branch_o(w_branch_o), .jump_o(w_jump_o),
    .alu_op_o(w_alu_op_o), .illegal_o(w_illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ill_instr [8] = '{32'h00009067, 32'h40001033, 32'h40000033, 32'h00003003,
                                 32'h00002023, 32'h00003023, 32'h00002063, 32'h02000033};
  logic        ill_exp   [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    step();
    step();
    check("rst_ready", ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_ctrl", ctrl_v, 0);
    check("rst_imm", imm_o, 0);
    check("rst_illegal", illegal_o, 0);

    // addi x1,x0,5
    rst_i = 1'b1; valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h100;
    #1 check("addi_ready", ready_o, 1);
    step();
    check("addi_valid", valid_o, 1);
    check("addi_ctrl", ctrl_v, 10'b110000_00_11);
    check("addi_imm", imm_o, 5);
    check("addi_rd", rd_o, 1);
    check("addi_rs2", rs2_o, 0);
    check("addi_pc", pc_o, 32'h100);

    // lw x2,0(x1) then dependent add x3,x2,x1
    instr_i = 32'h0000A103; pc_i = 32'h104;
    step();
    check("lw_ctrl", ctrl_v, 10'b111010_00_00);
    check("lw_rd", rd_o, 2);
    instr_i = 32'h001101B3; pc_i = 32'h108;
    #1 check("hazard_ready", ready_o, 0);
    step();
    check("bubble_valid", valid_o, 0);
    check("bubble_ready", ready_o, 1);
    step();
    check("add_valid", valid_o, 1);
    check("add_ctrl", ctrl_v, 10'b010000_00_10);
    check("add_regs", {rs1_o, rs2_o, rd_o}, {5'd2, 5'd1, 5'd3});
    check("add_pc", pc_o, 32'h108);

    // beq x0,x0,-4 then jal x1,8 back to back
    instr_i = 32'hFE000EE3; pc_i = 32'h10C;
    step();
    check("beq_ctrl", ctrl_v, 10'b000001_00_01);
    check("beq_imm", imm_o, 32'hFFFFFFFC);
    check("beq_imm64", w_imm_o, 64'hFFFFFFFFFFFFFFFC);
    check("beq_rd", rd_o, 0);
    instr_i = 32'h008000EF; pc_i = 32'h110;
    step();
    check("jal_ctrl", ctrl_v, 10'b010000_01_00);
    check("jal_imm", imm_o, 8);
    check("jal_regs", {rs1_o, rs2_o, rd_o}, {5'd0, 5'd0, 5'd1});

    // lui x5,0x12345 then the all-zero word
    instr_i = 32'h123452B7; pc_i = 32'h114;
    step();
    check("lui_ctrl", ctrl_v, 10'b110000_00_00);
    check("lui_imm", imm_o, 32'h12345000);
    check("lui_imm64", w_imm_o, 64'h12345000);
    check("lui_regs", {rs1_o, rd_o}, {5'd0, 5'd5});
    instr_i = 32'h00000000; pc_i = 32'h118;
    step();
    check("zero_valid", valid_o, 1);
    check("zero_illegal", illegal_o, 1);
    check("zero_ctrl", ctrl_v, 0);
    check("zero_imm", imm_o, 0);

    // funct3/funct7 legality boundaries
    for (int i = 0; i < 8; i++) begin
      instr_i = ill_instr[i];
      step();
      check($sformatf("illegal_%0d", i), illegal_o, ill_exp[i]);
    end
    valid_i = 1'b0;
    step();

    // backpressure: bundle held for 3 cycles
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h200;
    step();
    instr_i = 32'h123452B7; pc_i = 32'h204;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_ready_%0d", i), ready_o, 0);
      check($sformatf("hold_bundle_%0d", i), {valid_o, pc_o, imm_o}, {1'b1, 32'h200, 32'h5});
      step();
    end
    ready_i = 1'b1;
    #1 check("release_ready", ready_o, 1);
    step();
    check("release_bundle", {valid_o, pc_o, imm_o}, {1'b1, 32'h204, 32'h12345000});

    // flush kills held and incoming
    instr_i = 32'h00500093; pc_i = 32'h300;
    step();
    check("preflush_pc", pc_o, 32'h300);
    instr_i = 32'h123452B7; pc_i = 32'h304; flush_i = 1'b1; ready_i = 1'b0;
    #1 check("flush_ready", ready_o, 1);
    step();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    check("flush_valid", valid_o, 0);
    step();
    check("flush_gone", valid_o, 0);

    // reset while an illegal bundle is stalled
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h00000000; pc_i = 32'h400;
    step();
    check("prerst_illegal", illegal_o, 1);
    rst_i = 1'b0; instr_i = 32'h001101B3;
    #1 check("inrst_ready", ready_o, 0);
    step();
    check("midrst_out", {valid_o, illegal_o, ctrl_v, pc_o, imm_o, rd_o}, 0);
    check("midrst_out64", {w_valid_o, w_illegal_o, w_pc_o, w_imm_o}, 0);
    rst_i = 1'b1; ready_i = 1'b1; instr_i = 32'hFE000EE3; pc_i = 32'h500;
    #1 check("postrst_ready", ready_o, 1);
    step();
    check("postrst_valid", valid_o, 1);
    check("postrst_imm64", w_imm_o, 64'hFFFFFFFFFFFFFFFC);
    check("postrst_pc64", w_pc_o, 64'h500);
    valid_i = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
